// File: rtl/mel_mac_loop_ctrl.sv
// Nested outer/inner loop sequencer for the mel filterbank MAC: linear reads plus data-aligned
// accumulator control. Define MEL_MAC_ABORT_EN to add the abort input.
module mel_mac_loop_ctrl #(
    parameter int unsigned CNT_WIDTH  = 7,
    parameter int unsigned ADDR_WIDTH = 14,
    parameter int unsigned RD_LAT     = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  hold,
`ifdef MEL_MAC_ABORT_EN
    input  logic                  abort,
`endif
    input  logic [CNT_WIDTH-1:0]  outer_len,
    input  logic [CNT_WIDTH-1:0]  inner_len,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    output logic                  busy,
    output logic                  done,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [CNT_WIDTH-1:0]  outer_idx,
    output logic [CNT_WIDTH-1:0]  inner_idx,
    output logic                  acc_clr,
    output logic                  acc_en,
    output logic                  acc_last,
    output logic                  result_valid,
    output logic [CNT_WIDTH-1:0]  result_idx
);

    localparam int unsigned TW = CNT_WIDTH + 3;

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

    typedef struct packed {
        logic                 en;
        logic                 clr;
        logic                 last;
        logic [CNT_WIDTH-1:0] idx;
    } tag_t;

    state_e                  state_q;
    logic [CNT_WIDTH-1:0]    outer_len_q, inner_len_q;
    logic [CNT_WIDTH-1:0]    outer_q, inner_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [1:0]              drain_q;
    logic [RD_LAT*TW-1:0]    pipe_q, pipe_d;
    logic                    res_valid_q;
    logic [CNT_WIDTH-1:0]    res_idx_q;

    logic rd_fire;
    logic flush;
    tag_t rd_tag, out_tag;

`ifdef MEL_MAC_ABORT_EN
    assign flush = abort && (state_q != StIdle);
`else
    assign flush = 1'b0;
`endif

    assign rd_fire      = (state_q == StRun) && !hold;
    assign rd_tag.en    = rd_fire;
    assign rd_tag.clr   = rd_fire && (inner_q == '0);
    assign rd_tag.last  = rd_fire && (inner_q == inner_len_q);
    assign rd_tag.idx   = outer_q;

    // Tag shift register: newest tag enters at the low end, oldest leaves at the top.
    if (RD_LAT > 1) begin : g_shift
        assign pipe_d = {pipe_q[(RD_LAT-1)*TW-1:0], rd_tag};
    end else begin : g_single
        assign pipe_d = rd_tag;
    end
    assign out_tag = pipe_q[RD_LAT*TW-1 -: TW];

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            state_q     <= StIdle;
            outer_len_q <= '0;
            inner_len_q <= '0;
            outer_q     <= '0;
            inner_q     <= '0;
            addr_q      <= '0;
            drain_q     <= '0;
            pipe_q      <= '0;
            res_valid_q <= 1'b0;
            res_idx_q   <= '0;
        end else begin
            pipe_q      <= pipe_d;
            res_valid_q <= out_tag.last;
            res_idx_q   <= out_tag.idx;
            case (state_q)
                StIdle: begin
                    if (start) begin
                        outer_len_q <= outer_len;
                        inner_len_q <= inner_len;
                        outer_q     <= '0;
                        inner_q     <= '0;
                        addr_q      <= base_addr;
                        state_q     <= StRun;
                    end
                end
                StRun: begin
                    if (!hold) begin
                        addr_q <= addr_q + ADDR_WIDTH'(1);
                        if (inner_q == inner_len_q) begin
                            inner_q <= '0;
                            if (outer_q == outer_len_q) begin
                                drain_q <= '0;
                                state_q <= StDrain;
                            end else begin
                                outer_q <= outer_q + CNT_WIDTH'(1);
                            end
                        end else begin
                            inner_q <= inner_q + CNT_WIDTH'(1);
                        end
                    end
                end
                // RD_LAT+1 cycles lets the last result_valid land before DONE.
                StDrain: begin
                    if (drain_q == 2'(RD_LAT)) begin
                        state_q <= StDone;
                    end else begin
                        drain_q <= drain_q + 2'd1;
                    end
                end
                StDone: state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy         = (state_q != StIdle);
    assign done         = (state_q == StDone);
    assign rd_en        = rd_fire;
    assign rd_addr      = addr_q;
    assign outer_idx    = outer_q;
    assign inner_idx    = inner_q;
    assign acc_en       = out_tag.en;
    assign acc_clr      = out_tag.clr;
    assign acc_last     = out_tag.last;
    assign result_valid = res_valid_q;
    assign result_idx   = res_idx_q;

endmodule
